// File: rtl/bz_pkg.sv
// Shared types and constants for the buzzer melody player: FSM states,
// song entry layout and tone half-period table at 50 MHz.
package bz_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_DRAIN
   } state_t;

   typedef enum logic [3:0] {
      TONE_REST = 4'd0,
      TONE_END  = 4'd15
   } tone_code_t;

   localparam int TONE_W  = 4;
   localparam int LEN_W   = 2;
   localparam int ENTRY_W = TONE_W + LEN_W;
   localparam int HALF_W  = 17;
   localparam int CNT_W   = 28;

   localparam logic [ENTRY_W-1:0] END_ENTRY = {TONE_END, 2'd0};

   function automatic logic [ENTRY_W-1:0] mk_entry(input logic [TONE_W-1:0] tone,
                                                   input logic [LEN_W-1:0] len);
      return {tone, len};
   endfunction

   // Half periods in 50 MHz cycles, C4 through B5.
   function automatic logic [HALF_W-1:0] tone_half(input logic [TONE_W-1:0] tone);
      logic [HALF_W-1:0] h;
      case (tone)
         4'd1:    h = 17'd95556;
         4'd2:    h = 17'd85131;
         4'd3:    h = 17'd75843;
         4'd4:    h = 17'd71586;
         4'd5:    h = 17'd63776;
         4'd6:    h = 17'd56818;
         4'd7:    h = 17'd50619;
         4'd8:    h = 17'd47778;
         4'd9:    h = 17'd42566;
         4'd10:   h = 17'd37921;
         4'd11:   h = 17'd35793;
         4'd12:   h = 17'd31888;
         4'd13:   h = 17'd28409;
         4'd14:   h = 17'd25310;
         default: h = 17'd0;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/bz_song_rom.sv
// Combinational song ROM: address to {tone, len} entry.
// ROM_SEL picks the built-in melody (0) or small fixed test songs (1, 2).
module bz_song_rom
   import bz_pkg::*;
#(
   parameter int SONG_LEN = 32,
   parameter int ROM_SEL  = 0,
   localparam int AW      = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
   input  logic [AW-1:0]      addr,
   output logic [ENTRY_W-1:0] entry
);

   always_comb begin
      entry = END_ENTRY;
      case (ROM_SEL)
         1: begin
            case (int'(addr))
               0:       entry = mk_entry(4'd1, 2'd0);
               1:       entry = mk_entry(TONE_REST, 2'd1);
               default: entry = END_ENTRY;
            endcase
         end
         2: entry = END_ENTRY;
         default: begin
            // Twinkle Twinkle: C C G G A A G- F F E E D D C-
            case (int'(addr))
               0:       entry = mk_entry(4'd1, 2'd0);
               1:       entry = mk_entry(4'd1, 2'd0);
               2:       entry = mk_entry(4'd5, 2'd0);
               3:       entry = mk_entry(4'd5, 2'd0);
               4:       entry = mk_entry(4'd6, 2'd0);
               5:       entry = mk_entry(4'd6, 2'd0);
               6:       entry = mk_entry(4'd5, 2'd1);
               7:       entry = mk_entry(4'd4, 2'd0);
               8:       entry = mk_entry(4'd4, 2'd0);
               9:       entry = mk_entry(4'd3, 2'd0);
               10:      entry = mk_entry(4'd3, 2'd0);
               11:      entry = mk_entry(4'd2, 2'd0);
               12:      entry = mk_entry(4'd2, 2'd0);
               13:      entry = mk_entry(4'd1, 2'd1);
               default: entry = END_ENTRY;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/bz_melody_player.sv
// Song sequencer: loads one note at a time into the external beat counter,
// waits for beat_finish, and drives the buzzer square wave while a note plays.
module bz_melody_player
   import bz_pkg::*;
#(
   parameter logic [27:0] BEAT_UNIT  = 28'd12_500_000,
   parameter int          SONG_LEN   = 32,
   parameter int          TONE_SHIFT = 0,
   parameter int          ROM_SEL    = 0,
   localparam int         AW         = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic          stop,
   input  logic          loop,
   input  logic          beat_finish,
   output logic          beat_en,
   output logic [27:0]   beat_cnt_parameter,
   output logic          buzzer,
   output logic          busy,
   output logic [AW-1:0] note_idx
);

   if (({36'd0, BEAT_UNIT} << 3) > 64'd268435456) begin : g_beat_unit_check
      $error("BEAT_UNIT * 8 must not exceed 2**28");
   end

   localparam logic [AW-1:0] LAST_IDX = AW'(SONG_LEN - 1);

   state_t              state, state_nxt;
   logic [AW-1:0]       idx_nxt;
   logic [CNT_W-1:0]    param_nxt;
   logic [HALF_W-1:0]   half_per, half_nxt;
   logic [HALF_W-1:0]   div_cnt, div_nxt;
   logic                buz_nxt;
   logic                is_rest, rest_nxt;
   logic [ENTRY_W-1:0]  rom_entry;
   logic [TONE_W-1:0]   rom_tone;
   logic [LEN_W-1:0]    rom_len;

   bz_song_rom #(
      .SONG_LEN (SONG_LEN),
      .ROM_SEL  (ROM_SEL)
   ) u_rom (
      .addr  (note_idx),
      .entry (rom_entry)
   );

   assign rom_tone = rom_entry[ENTRY_W-1:LEN_W];
   assign rom_len  = rom_entry[LEN_W-1:0];
   assign beat_en  = (state == ST_PLAY) || (state == ST_DRAIN);
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state              <= ST_IDLE;
         note_idx           <= '0;
         beat_cnt_parameter <= '0;
         half_per           <= '0;
         div_cnt            <= '0;
         buzzer             <= 1'b0;
         is_rest            <= 1'b0;
      end else begin
         state              <= state_nxt;
         note_idx           <= idx_nxt;
         beat_cnt_parameter <= param_nxt;
         half_per           <= half_nxt;
         div_cnt            <= div_nxt;
         buzzer             <= buz_nxt;
         is_rest            <= rest_nxt;
      end
   end

   // The buzzer is forced low on every exit from PLAY so it never idles high.
   always_comb begin
      state_nxt = state;
      idx_nxt   = note_idx;
      param_nxt = beat_cnt_parameter;
      half_nxt  = half_per;
      div_nxt   = div_cnt;
      buz_nxt   = buzzer;
      rest_nxt  = is_rest;
      case (state)
         ST_IDLE: begin
            buz_nxt = 1'b0;
            if (start && !stop) begin
               state_nxt = ST_LOAD;
               idx_nxt   = '0;
            end
         end
         ST_LOAD: begin
            buz_nxt = 1'b0;
            if (stop) begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
            end else if (rom_tone == TONE_END) begin
               idx_nxt   = '0;
               state_nxt = (loop && (note_idx != '0)) ? ST_LOAD : ST_IDLE;
            end else begin
               param_nxt = (BEAT_UNIT << rom_len) - 28'd1;
               half_nxt  = tone_half(rom_tone) >> TONE_SHIFT;
               rest_nxt  = (rom_tone == TONE_REST);
               div_nxt   = '0;
               state_nxt = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (stop && beat_finish) begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
               buz_nxt   = 1'b0;
            end else if (stop) begin
               state_nxt = ST_DRAIN;
               buz_nxt   = 1'b0;
            end else if (beat_finish) begin
               buz_nxt = 1'b0;
               if (note_idx == LAST_IDX) begin
                  idx_nxt   = '0;
                  state_nxt = loop ? ST_LOAD : ST_IDLE;
               end else begin
                  idx_nxt   = note_idx + AW'(1);
                  state_nxt = ST_LOAD;
               end
            end else if (div_cnt == half_per - HALF_W'(1)) begin
               div_nxt = '0;
               buz_nxt = is_rest ? 1'b0 : ~buzzer;
            end else begin
               div_nxt = div_cnt + HALF_W'(1);
            end
         end
         ST_DRAIN: begin
            buz_nxt = 1'b0;
            if (beat_finish) begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bz_melody_player.sv
// Directed bench for bz_melody_player: three instances with small test ROMs
// and behavioural beat counters, checked with immediate assertions.
module tb_bz_melody_player;

   logic clk;
   logic rstn;
   logic start;
   logic stop;
   logic loop;

   logic        a_finish, a_beat_en, a_buzzer, a_busy;
   logic [27:0] a_param, a_cnt;
   logic [4:0]  a_idx;

   logic        b_finish, b_beat_en, b_buzzer, b_busy;
   logic [27:0] b_param, b_cnt;
   logic [0:0]  b_idx;

   logic        c_finish, c_beat_en, c_buzzer, c_busy;
   logic [27:0] c_param, c_cnt;
   logic [4:0]  c_idx;

   int checks = 0;
   int errors = 0;

   // Main instance: half period 95556 >> 10 = 93 cycles.
   bz_melody_player #(
      .BEAT_UNIT (28'd10), .SONG_LEN (32), .TONE_SHIFT (10), .ROM_SEL (1)
   ) dut_a (
      .clk (clk), .rstn (rstn), .start (start), .stop (stop), .loop (loop),
      .beat_finish (a_finish), .beat_en (a_beat_en), .beat_cnt_parameter (a_param),
      .buzzer (a_buzzer), .busy (a_busy), .note_idx (a_idx)
   );

   // Two-entry song, half period 95556 >> 14 = 5 cycles so the buzzer toggles.
   bz_melody_player #(
      .BEAT_UNIT (28'd10), .SONG_LEN (2), .TONE_SHIFT (14), .ROM_SEL (1)
   ) dut_b (
      .clk (clk), .rstn (rstn), .start (start), .stop (stop), .loop (loop),
      .beat_finish (b_finish), .beat_en (b_beat_en), .beat_cnt_parameter (b_param),
      .buzzer (b_buzzer), .busy (b_busy), .note_idx (b_idx)
   );

   // Song whose first entry is the end marker.
   bz_melody_player #(
      .BEAT_UNIT (28'd10), .SONG_LEN (32), .TONE_SHIFT (10), .ROM_SEL (2)
   ) dut_c (
      .clk (clk), .rstn (rstn), .start (start), .stop (stop), .loop (loop),
      .beat_finish (c_finish), .beat_en (c_beat_en), .beat_cnt_parameter (c_param),
      .buzzer (c_buzzer), .busy (c_busy), .note_idx (c_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Beat counter models: count 0..P while enabled, clear on the finish cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) a_cnt <= '0;
      else if (a_beat_en) a_cnt <= (a_cnt == a_param) ? 28'd0 : a_cnt + 28'd1;
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) b_cnt <= '0;
      else if (b_beat_en) b_cnt <= (b_cnt == b_param) ? 28'd0 : b_cnt + 28'd1;
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) c_cnt <= '0;
      else if (c_beat_en) c_cnt <= (c_cnt == c_param) ? 28'd0 : c_cnt + 28'd1;
   end
   assign a_finish = (a_cnt == a_param);
   assign b_finish = (b_cnt == b_param);
   assign c_finish = (c_cnt == c_param);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic start_v, input logic stop_v);
      start = start_v;
      stop  = stop_v;
      tick();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Counts cycles with a_beat_en high and buzzer-high cycles of A and B.
   task automatic measureBeat(output int n, output int hi_a, output int hi_b);
      n = 0;
      hi_a = 0;
      hi_b = 0;
      while (a_beat_en === 1'b1 && n < 200) begin
         n++;
         if (a_buzzer) hi_a++;
         if (b_buzzer) hi_b++;
         tick();
      end
   endtask

   int n, hi_a, hi_b;

   initial begin
      rstn  = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      loop  = 1'b0;
      #1 rstn = 1'b0;
      tick();
      tick();
      checkOutput("reset_busy", a_busy, 0);
      checkOutput("reset_beat_en", a_beat_en, 0);
      checkOutput("reset_buzzer", a_buzzer, 0);
      checkOutput("reset_idx", a_idx, 0);
      checkOutput("reset_param", a_param, 0);
      #2 rstn = 1'b1;
      tick();

      $display("[TB] basic play");
      applyStimulus(1'b1, 1'b0);
      checkOutput("load0_busy", a_busy, 1);
      checkOutput("load0_beat_en", a_beat_en, 0);
      checkOutput("load0_idx", a_idx, 0);
      checkOutput("c_load_busy", c_busy, 1);
      tick();
      checkOutput("c_end_idle", c_busy, 0);
      checkOutput("note0_param", a_param, 9);
      checkOutput("b_note0_param", b_param, 9);
      measureBeat(n, hi_a, hi_b);
      checkOutput("note0_len", n, 10);
      checkOutput("note0_buz_a", hi_a, 0);
      checkOutput("note0_buz_b", hi_b, 5);
      checkOutput("load1_beat_en", a_beat_en, 0);
      checkOutput("load1_idx", a_idx, 1);
      tick();
      checkOutput("note1_param", a_param, 19);
      measureBeat(n, hi_a, hi_b);
      checkOutput("note1_len", n, 20);
      checkOutput("note1_rest_a", hi_a, 0);
      checkOutput("note1_rest_b", hi_b, 0);
      checkOutput("load2_busy", a_busy, 1);
      checkOutput("load2_idx", a_idx, 2);
      checkOutput("b_last_idle", b_busy, 0);
      checkOutput("b_last_idx", b_idx, 0);
      tick();
      checkOutput("end_busy", a_busy, 0);
      checkOutput("end_idx", a_idx, 0);

      $display("[TB] loop");
      loop = 1'b1;
      applyStimulus(1'b1, 1'b0);
      checkOutput("c_loop_load", c_busy, 1);
      tick();
      checkOutput("c_loop_idle", c_busy, 0);
      measureBeat(n, hi_a, hi_b);
      checkOutput("loop_note0_len", n, 10);
      tick();
      measureBeat(n, hi_a, hi_b);
      checkOutput("loop_note1_len", n, 20);
      checkOutput("loop_load2_idx", a_idx, 2);
      checkOutput("b_wrap_busy", b_busy, 1);
      checkOutput("b_wrap_idx", b_idx, 0);
      tick();
      checkOutput("loop_wrap_busy", a_busy, 1);
      checkOutput("loop_wrap_beat_en", a_beat_en, 0);
      checkOutput("loop_wrap_idx", a_idx, 0);
      checkOutput("b_wrap_play", b_beat_en, 1);
      tick();
      checkOutput("loop_replay_param", a_param, 9);
      checkOutput("loop_replay_beat_en", a_beat_en, 1);

      $display("[TB] stop mid-note");
      loop = 1'b0;
      repeat (3) tick();
      applyStimulus(1'b0, 1'b1);
      checkOutput("drain_buzzer", a_buzzer, 0);
      checkOutput("drain_beat_en", a_beat_en, 1);
      checkOutput("drain_busy", a_busy, 1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("drain_start_ign", a_beat_en, 1);
      measureBeat(n, hi_a, hi_b);
      checkOutput("drain_rest_len", n, 5);
      checkOutput("drain_idle_busy", a_busy, 0);
      checkOutput("drain_idle_idx", a_idx, 0);
      tick();
      checkOutput("drain_no_restart", a_busy, 0);

      $display("[TB] restart and collisions");
      applyStimulus(1'b1, 1'b0);
      tick();
      checkOutput("restart_param", a_param, 9);
      measureBeat(n, hi_a, hi_b);
      checkOutput("restart_len", n, 10);
      tick();
      tick();
      tick();
      applyStimulus(1'b1, 1'b0);
      checkOutput("start_in_play_idx", a_idx, 1);
      checkOutput("start_in_play_en", a_beat_en, 1);
      repeat (16) tick();
      checkOutput("pre_finish_en", a_finish, 1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("stop_finish_busy", a_busy, 0);
      checkOutput("stop_finish_en", a_beat_en, 0);
      checkOutput("stop_finish_idx", a_idx, 0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("start_stop_idle", a_busy, 0);
      tick();
      checkOutput("start_stop_idle2", a_busy, 0);

      $display("[TB] reset during play");
      applyStimulus(1'b1, 1'b0);
      tick();
      repeat (6) tick();
      checkOutput("pre_reset_b_buzzer", b_buzzer, 1);
      checkOutput("pre_reset_beat_en", a_beat_en, 1);
      #2 rstn = 1'b0;
      #1;
      checkOutput("async_busy", a_busy, 0);
      checkOutput("async_beat_en", a_beat_en, 0);
      checkOutput("async_idx", a_idx, 0);
      checkOutput("async_param", a_param, 0);
      checkOutput("async_b_buzzer", b_buzzer, 0);
      #3 rstn = 1'b1;
      tick();
      checkOutput("post_reset_idle", a_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
